// File: rtl/seg_pkg.sv
// Shared types and constants for the 7-segment scroll controller.
package seg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    EXT   = 2'd3
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  // Power-on contents of the character table (bit6=a ... bit0=g).
  function automatic logic [6:0] default_msg(input logic [2:0] i);
    logic [6:0] v;
    case (i)
      3'd0:    v = 7'b0110000;
      3'd1:    v = 7'b1111011;
      3'd2:    v = 7'b1111110;
      3'd3:    v = 7'b1111001;
      3'd4:    v = 7'b1111110;
      3'd5:    v = 7'b0110011;
      3'd6:    v = 7'b0110000;
      default: v = 7'b1111011;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/seg_tick_div.sv
// Rate divider: one-cycle tick every DIV_MAX+1 cycles while run is high.
// Counter is held at zero whenever run is low or clr is asserted.
module seg_tick_div #(
  parameter int DIV_MAX = 2,
  parameter int CNT_W   = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clr,
  output logic tick
);

  logic [CNT_W-1:0] cnt;

  assign tick = run && (cnt == CNT_W'(DIV_MAX));

  // Free-running count while enabled, wrapping to zero on the tick.
  always_ff @(posedge clk) begin
    if (rst || clr || !run) cnt <= '0;
    else if (tick)          cnt <= '0;
    else                    cnt <= cnt + CNT_W'(1);
  end

endmodule

// File: rtl/seg_scroll_ctrl.sv
// Scroll scheduler for a single 7-segment digit: steps an 8-entry writable
// character table at the divided rate and lends the display to one external
// requester. Optional macro SEG_BLINK_EN makes the paused character blink.
module seg_scroll_ctrl
  import seg_pkg::*;
#(
  parameter int DIV_MAX = 2,
  parameter int CNT_W   = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       pause,
  input  logic       wr_en,
  input  logic [2:0] wr_addr,
  input  logic [6:0] wr_data,
  input  logic       ext_req,
  input  logic [6:0] ext_seg,
  output logic       ext_grant,
  output logic [6:0] out,
  output logic       sel,
  output logic [2:0] idx,
  output logic       wrap,
  output logic       busy
);

  state_t     state;
  state_t     saved;
  logic [6:0] tbl [8];
  logic       tick;
  logic       run;
  logic       clr;
  logic [6:0] shown;

`ifdef SEG_BLINK_EN
  logic       blink_off;
  assign run   = (state == RUN) || (state == PAUSE);
  assign shown = (state == PAUSE && blink_off) ? SEG_BLANK : tbl[idx];
`else
  assign run   = (state == RUN);
  assign shown = tbl[idx];
`endif

  // Restart the period on every RUN/PAUSE boundary and on abort.
  assign clr  = stop || (state == RUN && pause) || (state == PAUSE && !pause);
  assign busy = (state != IDLE);
  assign sel  = 1'b0;

  seg_tick_div #(.DIV_MAX(DIV_MAX), .CNT_W(CNT_W)) u_div (
    .clk  (clk),
    .rst  (rst),
    .run  (run),
    .clr  (clr),
    .tick (tick)
  );

  // Scheduler FSM, character table and registered display drive.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      saved     <= IDLE;
      idx       <= 3'd0;
      out       <= SEG_BLANK;
      ext_grant <= 1'b0;
      wrap      <= 1'b0;
`ifdef SEG_BLINK_EN
      blink_off <= 1'b0;
`endif
      for (int i = 0; i < 8; i++) tbl[i] <= default_msg(3'(i));
    end else begin
      wrap <= 1'b0;
      if (wr_en) tbl[wr_addr] <= wr_data;

      // Display follows the current state; abort blanks immediately.
      case (state)
        IDLE:    out <= SEG_BLANK;
        EXT:     out <= ext_seg;
        default: out <= shown;
      endcase

      if (stop) begin
        state     <= IDLE;
        idx       <= 3'd0;
        ext_grant <= 1'b0;
        out       <= SEG_BLANK;
      end else begin
        case (state)
          IDLE: begin
            if (ext_req) begin
              state     <= EXT;
              saved     <= IDLE;
              ext_grant <= 1'b1;
            end else if (start) begin
              state <= RUN;
              idx   <= 3'd0;
            end
          end
          RUN: begin
            // External grant waits for the period boundary and eats that step.
            if (tick && ext_req) begin
              state     <= EXT;
              saved     <= RUN;
              ext_grant <= 1'b1;
            end else if (pause) begin
              state <= PAUSE;
`ifdef SEG_BLINK_EN
              blink_off <= 1'b0;
`endif
            end else if (tick) begin
              idx  <= idx + 3'd1;
              wrap <= (idx == 3'd7);
            end
          end
          PAUSE: begin
            if (ext_req) begin
              state     <= EXT;
              saved     <= PAUSE;
              ext_grant <= 1'b1;
            end else if (!pause) begin
              state <= RUN;
            end
`ifdef SEG_BLINK_EN
            else if (tick) begin
              blink_off <= ~blink_off;
            end
`endif
          end
          default: begin
            if (!ext_req) begin
              state     <= saved;
              ext_grant <= 1'b0;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seg_scroll_ctrl.sv
// Directed self-checking bench for seg_scroll_ctrl (default build, DIV_MAX=2).
module tb_seg_scroll_ctrl;

  logic       clk = 1'b0;
  logic       rst, start, stop, pause, wr_en, ext_req;
  logic [2:0] wr_addr;
  logic [6:0] wr_data, ext_seg;
  logic       ext_grant, sel, wrap, busy;
  logic [6:0] out;
  logic [2:0] idx;

  int n_checks = 0;
  int n_fail   = 0;
  logic [6:0] msg [8];

  always #5 clk = ~clk;

  seg_scroll_ctrl #(.DIV_MAX(2), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .ext_req(ext_req), .ext_seg(ext_seg), .ext_grant(ext_grant),
    .out(out), .sel(sel), .idx(idx), .wrap(wrap), .busy(busy)
  );

  // Advance one clock and settle past the edge before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Step until idx reaches target (bounded).
  task automatic wait_idx(input logic [2:0] target);
    int k;
    k = 0;
    while (idx !== target && k < 60) begin
      step();
      k++;
    end
    n_checks++;
    if (idx !== target) begin
      n_fail++;
      $display("FAIL wait_idx: idx=%0d want %0d", idx, target);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; step(); step(); rst = 1'b0;
    n_checks++;
    if (idx !== 3'd0 || out !== 7'b0 || ext_grant !== 1'b0 || wrap !== 1'b0 ||
        busy !== 1'b0 || sel !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: idx=%0d out=%b grant=%b wrap=%b busy=%b sel=%b want 0",
               idx, out, ext_grant, wrap, busy, sel);
    end
  endtask

  task automatic test_scroll();
    start = 1'b1; step(); start = 1'b0;
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL scroll_busy: busy=%b want 1", busy); end
    for (int k = 0; k < 8; k++) begin
      n_checks++;
      if (idx !== 3'(k) || wrap !== 1'b0) begin
        n_fail++;
        $display("FAIL scroll_idx: idx=%0d wrap=%b want idx=%0d wrap=0", idx, wrap, k);
      end
      step();
      n_checks++;
      if (out !== msg[k]) begin
        n_fail++;
        $display("FAIL scroll_out: out=%b want %b at idx %0d", out, msg[k], k);
      end
      step(); step();
    end
    n_checks++;
    if (idx !== 3'd0 || wrap !== 1'b1) begin
      n_fail++;
      $display("FAIL scroll_wrap: idx=%0d wrap=%b want idx=0 wrap=1", idx, wrap);
    end
    step();
    n_checks++;
    if (wrap !== 1'b0 || out !== msg[0]) begin
      n_fail++;
      $display("FAIL scroll_wrap_end: wrap=%b out=%b want 0 / %b", wrap, out, msg[0]);
    end
  endtask

  task automatic test_pause();
    int bad;
    wait_idx(3'd3);
    pause = 1'b1;
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (idx !== 3'd3 || out !== 7'b1111001) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL pause_hold: %0d bad cycles, last idx=%0d out=%b want 3 / 1111001", bad, idx, out);
    end
    pause = 1'b0;
    step(); step(); step();
    n_checks++;
    if (idx !== 3'd3) begin n_fail++; $display("FAIL resume_early: idx=%0d want 3", idx); end
    step();
    n_checks++;
    if (idx !== 3'd4) begin n_fail++; $display("FAIL resume_step: idx=%0d want 4", idx); end
  endtask

  task automatic test_arbitration();
    wait_idx(3'd5);
    step();
    ext_req = 1'b1; ext_seg = 7'b1001111;
    step();
    n_checks++;
    if (ext_grant !== 1'b0) begin n_fail++; $display("FAIL arb_early: grant=%b want 0", ext_grant); end
    step();
    n_checks++;
    if (ext_grant !== 1'b1 || idx !== 3'd5) begin
      n_fail++;
      $display("FAIL arb_grant: grant=%b idx=%0d want 1 / 5", ext_grant, idx);
    end
    step();
    n_checks++;
    if (out !== 7'b1001111) begin n_fail++; $display("FAIL arb_out: out=%b want 1001111", out); end
    ext_req = 1'b0;
    step();
    n_checks++;
    if (ext_grant !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL arb_release: grant=%b busy=%b want 0 / 1", ext_grant, busy);
    end
    step();
    n_checks++;
    if (out !== 7'b0110011 || idx !== 3'd5) begin
      n_fail++;
      $display("FAIL arb_resume: out=%b idx=%0d want 0110011 / 5", out, idx);
    end
  endtask

  task automatic test_stop_priority();
    stop = 1'b1; ext_req = 1'b1; start = 1'b1;
    step();
    stop = 1'b0; ext_req = 1'b0; start = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || ext_grant !== 1'b0 || out !== 7'b0 || idx !== 3'd0) begin
      n_fail++;
      $display("FAIL stop_prio: busy=%b grant=%b out=%b idx=%0d want 0", busy, ext_grant, out, idx);
    end
    // Grant from IDLE, then revoke it with stop.
    ext_req = 1'b1; ext_seg = 7'b0001110;
    step();
    n_checks++;
    if (ext_grant !== 1'b1) begin n_fail++; $display("FAIL idle_grant: grant=%b want 1", ext_grant); end
    step();
    stop = 1'b1;
    step();
    stop = 1'b0; ext_req = 1'b0;
    n_checks++;
    if (ext_grant !== 1'b0 || out !== 7'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL stop_revoke: grant=%b out=%b busy=%b want 0", ext_grant, out, busy);
    end
  endtask

  task automatic test_live_write();
    start = 1'b1; step(); start = 1'b0;
    wait_idx(3'd2);
    wr_en = 1'b1; wr_addr = 3'd2; wr_data = 7'b1110111;
    step();
    wr_en = 1'b0;
    n_checks++;
    if (out !== msg[2]) begin n_fail++; $display("FAIL write_old: out=%b want %b", out, msg[2]); end
    step();
    n_checks++;
    if (out !== 7'b1110111) begin n_fail++; $display("FAIL write_new: out=%b want 1110111", out); end
  endtask

  task automatic test_reset_mid_ext();
    int k;
    ext_req = 1'b1; ext_seg = 7'b1001111;
    k = 0;
    while (ext_grant !== 1'b1 && k < 20) begin step(); k++; end
    n_checks++;
    if (ext_grant !== 1'b1) begin n_fail++; $display("FAIL ext_timeout: grant=%b want 1", ext_grant); end
    rst = 1'b1; wr_en = 1'b1; wr_addr = 3'd0; wr_data = 7'b1111111;
    step();
    rst = 1'b0; wr_en = 1'b0; ext_req = 1'b0;
    n_checks++;
    if (ext_grant !== 1'b0 || out !== 7'b0 || busy !== 1'b0 || idx !== 3'd0) begin
      n_fail++;
      $display("FAIL rst_ext: grant=%b out=%b busy=%b idx=%0d want 0", ext_grant, out, busy, idx);
    end
    start = 1'b1; step(); start = 1'b0;
    step();
    n_checks++;
    if (out !== msg[0]) begin n_fail++; $display("FAIL rst_tbl0: out=%b want %b", out, msg[0]); end
    wait_idx(3'd2);
    step();
    n_checks++;
    if (out !== msg[2]) begin n_fail++; $display("FAIL rst_tbl2: out=%b want %b", out, msg[2]); end
  endtask

  initial begin
    msg[0] = 7'b0110000; msg[1] = 7'b1111011; msg[2] = 7'b1111110; msg[3] = 7'b1111001;
    msg[4] = 7'b1111110; msg[5] = 7'b0110011; msg[6] = 7'b0110000; msg[7] = 7'b1111011;
    rst = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0; wr_en = 1'b0;
    wr_addr = 3'd0; wr_data = 7'd0; ext_req = 1'b0; ext_seg = 7'd0;
    test_reset();
    test_scroll();
    test_pause();
    test_arbitration();
    test_stop_priority();
    test_live_write();
    test_reset_mid_ext();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
